// File: rtl/calc_sequencer.sv
// Operand/result sequencer for a 4-bit add/sub stage: debounces the enter button and
// steps GET_A -> GET_B -> CALC -> SHOW, latching operands and the downstream result.
module calc_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       op_sel,
    input  logic       btn_enter,
    input  logic [3:0] r,
    input  logic       ovf,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       co,
    output logic [3:0] result,
    output logic       result_ovf,
    output logic [1:0] state,
    output logic       done
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StGetA = 2'b00,
        StGetB = 2'b01,
        StCalc = 2'b10,
        StShow = 2'b11
    } st_e;

    st_e            st_q;
    logic           sync1_q, sync2_q;
    logic           level_q, level_prev_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]     vld_q;
    logic           armed_q;
    logic           press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_enter;
            sync2_q <= sync1_q;
        end
    end

    // Events are only armed once the synchronised button has been seen released after
    // reset, so a button held through reset never produces a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            vld_q        <= 2'b00;
            armed_q      <= 1'b0;
        end else begin
            if (sync2_q != level_q) begin
                if (cnt_q == CntMax) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
            level_prev_q <= level_q;
            vld_q        <= {vld_q[0], 1'b1};
            armed_q      <= armed_q | (vld_q[1] & ~sync2_q);
        end
    end

    assign press = level_q & ~level_prev_q & armed_q;

    // Presses in CALC are simply not looked at, so they are dropped rather than queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= StGetA;
            a          <= 4'd0;
            b          <= 4'd0;
            co         <= 1'b0;
            result     <= 4'd0;
            result_ovf <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (st_q)
                StGetA: begin
                    if (press) begin
                        a    <= sw;
                        st_q <= StGetB;
                    end
                end
                StGetB: begin
                    if (press) begin
                        b    <= sw;
                        co   <= op_sel;
                        st_q <= StCalc;
                    end
                end
                StCalc: begin
                    result     <= r;
                    result_ovf <= ovf;
                    done       <= 1'b1;
                    st_q       <= StShow;
                end
                StShow: begin
                    if (press) begin
                        done <= 1'b0;
                        st_q <= StGetA;
                    end
                end
                default: st_q <= StGetA;
            endcase
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural 4-bit add/sub stage attached.
module tb_calc_sequencer;

    localparam int unsigned D = 16;

    logic       clk, rst;
    logic [3:0] sw;
    logic       op_sel, btn_enter;
    logic [3:0] r;
    logic       ovf;
    logic [3:0] a, b, result;
    logic       co, result_ovf, done;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    calc_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .op_sel     (op_sel),
        .btn_enter  (btn_enter),
        .r          (r),
        .ovf        (ovf),
        .a          (a),
        .b          (b),
        .co         (co),
        .result     (result),
        .result_ovf (result_ovf),
        .state      (state),
        .done       (done)
    );

    // Downstream add/sub stage.
    always_comb begin
        r   = co ? (a - b) : (a + b);
        ovf = co ? ((a[3] != b[3]) && (r[3] != a[3])) : ((a[3] == b[3]) && (r[3] != a[3]));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press();
        btn_enter = 1'b1;
        repeat (D + 8) @(negedge clk);
        btn_enter = 1'b0;
        repeat (D + 8) @(negedge clk);
    endtask

    task automatic operate(input logic [3:0] va, input logic [3:0] vb, input logic sub);
        sw = va;
        press();
        sw     = vb;
        op_sel = sub;
        press();
    endtask

    int lat;
    int trans;
    logic [1:0] prev;

    initial begin
        rst = 1'b1; sw = 4'd0; op_sel = 1'b0; btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_ovf", 32'(result_ovf), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Add 0101 + 0011 with press latency measured on the first press.
        sw = 4'b0101;
        btn_enter = 1'b1;
        lat = 0;
        while (state == 2'b00 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("lat_max", 32'(lat <= D + 4), 32'd1);
        check("lat_min", 32'(lat >= D), 32'd1);
        repeat (D + 8) @(negedge clk);
        btn_enter = 1'b0;
        repeat (D + 8) @(negedge clk);
        check("add_state_b", 32'(state), 32'd1);
        check("add_a", 32'(a), 32'h5);
        sw = 4'b0011; op_sel = 1'b0;
        press();
        check("add_state", 32'(state), 32'd3);
        check("add_b", 32'(b), 32'h3);
        check("add_co", 32'(co), 32'd0);
        check("add_result", 32'(result), 32'h8);
        check("add_ovf", 32'(result_ovf), 32'd1);
        check("add_done", 32'(done), 32'd1);

        // Wrap back to GET_A; result held, sw ignored without a press.
        press();
        check("wrap_state", 32'(state), 32'd0);
        check("wrap_done", 32'(done), 32'd0);
        check("wrap_result", 32'(result), 32'h8);
        sw = 4'hF;
        repeat (10) @(negedge clk);
        check("hold_a", 32'(a), 32'h5);

        operate(4'b0111, 4'b0010, 1'b1);
        check("sub_state", 32'(state), 32'd3);
        check("sub_result", 32'(result), 32'h5);
        check("sub_ovf", 32'(result_ovf), 32'd0);
        check("sub_co", 32'(co), 32'd1);
        press();

        operate(4'b1000, 4'b0001, 1'b1);
        check("subovf_result", 32'(result), 32'h7);
        check("subovf_ovf", 32'(result_ovf), 32'd1);
        press();
        check("subovf_back", 32'(state), 32'd0);

        // Short bounces must be rejected; one long hold gives a single transition.
        sw = 4'h9;
        for (int i = 0; i < 5; i++) begin
            btn_enter = 1'b1;
            repeat (D - 2) @(negedge clk);
            btn_enter = 1'b0;
            repeat (6) @(negedge clk);
        end
        repeat (D) @(negedge clk);
        check("bounce_state", 32'(state), 32'd0);
        prev = state; trans = 0;
        btn_enter = 1'b1;
        for (int i = 0; i < 100 + D + 8; i++) begin
            if (i == 100) btn_enter = 1'b0;
            @(negedge clk);
            if (state != prev) trans++;
            prev = state;
        end
        check("hold_trans", 32'(trans), 32'd1);
        check("hold_state", 32'(state), 32'd1);
        check("hold_a", 32'(a), 32'h9);

        // Asynchronous reset mid-cycle in GET_B.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_a", 32'(a), 32'd0);
        check("arst_b", 32'(b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        operate(4'b0011, 4'b0100, 1'b0);
        check("seq2_state", 32'(state), 32'd3);
        check("seq2_result", 32'(result), 32'h7);
        check("seq2_ovf", 32'(result_ovf), 32'd0);
        press();
        check("seq2_wrap_result", 32'(result), 32'h7);

        // Button held through reset must not fire until released and pressed again.
        btn_enter = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * D) @(negedge clk);
        check("held_rst_state", 32'(state), 32'd0);
        btn_enter = 1'b0;
        repeat (D + 8) @(negedge clk);
        check("held_rel_state", 32'(state), 32'd0);
        sw = 4'h6;
        press();
        check("held_repress_state", 32'(state), 32'd1);
        check("held_repress_a", 32'(a), 32'h6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYCLES, default 16, giving the number of consecutive stable cycles the synchronised button needs before a level change is accepted.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sw  input  4  operand entry switches (two's complement).
REQ-006 op_sel  input  1  operation select: 0 = add, 1 = subtract.
REQ-007 btn_enter  input  1  raw, asynchronous, bouncy enter button.
REQ-008 r  input  4  result from the downstream 4-bit add/sub stage.
REQ-009 ovf  input  1  signed-overflow flag from the downstream add/sub stage.
REQ-010 a  output  4  operand A, driven to the add/sub stage.
REQ-011 b  output  4  operand B, driven to the add/sub stage.
REQ-012 co  output  1  subtract control / carry-in, driven to the add/sub stage.
REQ-013 result  output  4  captured result.
REQ-014 result_ovf  output  1  captured overflow flag.
REQ-015 state  output  2  current FSM state encoding.
REQ-016 done  output  1  high while a result is displayed.

Function
REQ-017 btn_enter SHALL pass through a 2-flop synchroniser before any other use.
REQ-018 A debounce counter SHALL update the debounced level only after the synchronised input has differed from that level for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the counter.
REQ-019 An internal press event SHALL be a one-cycle pulse on each 0->1 transition of the debounced level; a held button SHALL yield exactly one event.
REQ-020 The FSM states SHALL be encoded as GET_A=00, GET_B=01, CALC=10, SHOW=11.
REQ-021 GET_A: on a press event, a <= sw and the FSM goes to GET_B.
REQ-022 GET_B: on a press event, b <= sw, co <= op_sel and the FSM goes to CALC.
REQ-023 CALC: with no condition, result <= r and result_ovf <= ovf on the next edge, and the FSM goes to SHOW; CALC SHALL last exactly one cycle.
REQ-024 SHOW: done = 1; on a press event the FSM goes to GET_A; a, b, co, result and result_ovf are held until overwritten.
REQ-025 A press event arriving in CALC SHALL be discarded and SHALL NOT be queued.
REQ-026 a, b and co SHALL change only in the states named in REQ-021 and REQ-022; sw and op_sel changes at any other time SHALL have no effect.
REQ-027 done SHALL be a registered output, asserted the cycle the FSM enters SHOW and deasserted the cycle it leaves.
REQ-028 The worst-case latency from a clean btn_enter rise to the resulting state change SHALL be DEBOUNCE_CYCLES + 4 clk cycles.
REQ-029 The block SHALL perform no arithmetic itself; it relies entirely on r and ovf from the add/sub stage.

Reset
REQ-030 While rst = 1, all outputs SHALL be held at: state = GET_A, a = 0, b = 0, co = 0, result = 0, result_ovf = 0, done = 0.
REQ-031 While rst = 1, the synchroniser flops, the debounced level and the debounce counter SHALL be cleared.
REQ-032 Assertion of rst in any state, including CALC, SHALL abort the operation immediately without waiting for a clock edge.
REQ-033 After rst deasserts with btn_enter already high, no press event SHALL be produced until the button is released and pressed again.

Verification
REQ-034 Add: sw = 0101, press; sw = 0011, op_sel = 0, press -> SHOW with result = 1000, result_ovf = 1, done = 1.
REQ-035 Subtract: A = 0111, B = 0010, op_sel = 1 -> result = 0101, result_ovf = 0, co = 1.
REQ-036 Subtract with overflow: A = 1000, B = 0001, op_sel = 1 -> result = 0111, result_ovf = 1.
REQ-037 Bounce: btn_enter pulses of length DEBOUNCE_CYCLES - 2 in GET_A -> state stays 00; one press held for 100 cycles -> exactly one transition, to 01.
REQ-038 Reset in GET_B: assert rst asynchronously mid-cycle -> state = 00 and a = 0 immediately, before the next clock edge.
REQ-039 Wrap: from SHOW, press -> GET_A with result retained; a second full sequence (A = 0011, B = 0100, add) -> result = 0111, result_ovf = 0.
